// File: rtl/matrix_scan_param_if.sv
// Signal bundle between the HUB75 scan controller and the panel/framebuffer side.
// The controller drives addressing and panel strobes and samples enable.
interface matrix_scan_param_if #(
    parameter int COLUMNS   = 64,
    parameter int ROW_BITS  = 4,
    parameter int BIT_DEPTH = 6
);
    localparam int COL_W   = $clog2(COLUMNS);
    localparam int PLANE_W = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;

    logic                enable;
    logic [COL_W-1:0]    column_address;
    logic [ROW_BITS-1:0] row_address;
    logic [ROW_BITS-1:0] row_address_active;
    logic [PLANE_W-1:0]  plane;
    logic [PLANE_W-1:0]  plane_active;
    logic                pixel_req;
    logic                clk_pixel;
    logic                row_latch;
    logic                oe_n;
    logic                frame_start;

    modport master (
        input  enable,
        output column_address, row_address, row_address_active, plane, plane_active,
        output pixel_req, clk_pixel, row_latch, oe_n, frame_start
    );

    modport slave (
        output enable,
        input  column_address, row_address, row_address_active, plane, plane_active,
        input  pixel_req, clk_pixel, row_latch, oe_n, frame_start
    );
endinterface

// File: rtl/matrix_scan_param.sv
// HUB75 scan controller: shifts one row/plane while the previous one is displayed,
// then latches it and runs a binary-weighted OE pulse for the latched plane.
module matrix_scan_param #(
    parameter int COLUMNS      = 64,
    parameter int ROW_BITS     = 4,
    parameter int BIT_DEPTH    = 6,
    parameter int BASE_TICKS   = 23,
    parameter int MIN_OE_TICKS = 1,
    parameter int LATCH_CYCLES = 1
) (
    input logic                 clk_in,
    input logic                 reset,
    matrix_scan_param_if.master bus
);
    localparam int COL_W   = $clog2(COLUMNS);
    localparam int PLANE_W = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
    localparam int LONGEST = BASE_TICKS << (BIT_DEPTH - 1);
    localparam int MAX_OE  = (LONGEST > MIN_OE_TICKS) ? LONGEST : MIN_OE_TICKS;
    localparam int OE_W    = $clog2(MAX_OE + 1);
    localparam int LATCH_W = $clog2(LATCH_CYCLES + 1);

    typedef enum logic [1:0] {ST_SHIFT, ST_WAIT, ST_LATCH} state_t;

    state_t             state;
    logic [OE_W-1:0]    oe_count;
    logic [LATCH_W-1:0] latch_count;

    // OE timer holds remaining-cycles-minus-one so the pulse is exactly the reload length.
    function automatic logic [OE_W-1:0] oe_reload(input logic [PLANE_W-1:0] p);
        int ticks;
        ticks = BASE_TICKS << p;
        if (ticks < MIN_OE_TICKS) ticks = MIN_OE_TICKS;
        return OE_W'(ticks - 1);
    endfunction

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state                  <= ST_SHIFT;
            oe_count               <= '0;
            latch_count            <= '0;
            bus.column_address     <= COL_W'(COLUMNS - 1);
            bus.row_address        <= '0;
            bus.row_address_active <= '0;
            bus.plane              <= PLANE_W'(BIT_DEPTH - 1);
            bus.plane_active       <= PLANE_W'(BIT_DEPTH - 1);
            bus.pixel_req          <= 1'b0;
            bus.clk_pixel          <= 1'b0;
            bus.row_latch          <= 1'b0;
            bus.oe_n               <= 1'b1;
            bus.frame_start        <= 1'b0;
        end else begin
            bus.frame_start <= 1'b0;

            if (!bus.oe_n) begin
                if (oe_count == '0) bus.oe_n <= 1'b1;
                else oe_count <= oe_count - 1'b1;
            end

            case (state)
                // Phase A (pixel_req) and phase B (clk_pixel) alternate; both low only on the first cycle after reset.
                ST_SHIFT: begin
                    if (bus.pixel_req) begin
                        bus.pixel_req <= 1'b0;
                        bus.clk_pixel <= 1'b1;
                    end else if (bus.clk_pixel) begin
                        bus.clk_pixel <= 1'b0;
                        if (bus.column_address == '0) begin
                            state <= ST_WAIT;
                        end else begin
                            bus.column_address <= bus.column_address - 1'b1;
                            bus.pixel_req      <= 1'b1;
                        end
                    end else begin
                        bus.pixel_req <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (bus.oe_n && bus.enable) begin
                        state         <= ST_LATCH;
                        bus.row_latch <= 1'b1;
                        latch_count   <= LATCH_W'(LATCH_CYCLES - 1);
                    end
                end

                ST_LATCH: begin
                    if (latch_count == '0) begin
                        state                  <= ST_SHIFT;
                        bus.row_latch          <= 1'b0;
                        bus.row_address_active <= bus.row_address;
                        bus.plane_active       <= bus.plane;
                        bus.column_address     <= COL_W'(COLUMNS - 1);
                        bus.pixel_req          <= 1'b1;
                        bus.oe_n               <= 1'b0;
                        oe_count               <= oe_reload(bus.plane);
                        bus.frame_start        <= (bus.row_address == '0) &&
                                                  (bus.plane == PLANE_W'(BIT_DEPTH - 1));
                        if (bus.plane == '0) begin
                            bus.plane       <= PLANE_W'(BIT_DEPTH - 1);
                            bus.row_address <= bus.row_address + ROW_BITS'(1);
                        end else begin
                            bus.plane <= bus.plane - 1'b1;
                        end
                    end else begin
                        latch_count <= latch_count - 1'b1;
                    end
                end

                default: state <= ST_SHIFT;
            endcase
        end
    end
endmodule
